cache_mem_arbiter: RTL and testbench

- Shares the single physical-memory port between the instruction cache and the data cache miss/writeback paths.
- Sits between the two cache controllers' pmem-side interfaces and main memory (or L2).
- Serialises line transfers and grants round-robin when both sides request.
- Provides saturating per-requester grant counters for performance debug.

---
 rtl/cache_mem_arbiter.sv | 111 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single memory port between I-cache and D-cache line transfers,
// granting round-robin on contention, with saturating per-side completion counters.
module cache_mem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  // Handshake: a requester holds its request, address and data stable until
  // its resp pulse; resp is high for exactly the cycle mem_resp is seen while
  // that side owns the grant, and read data is valid only in that cycle.

  typedef enum logic [1:0] {
    s_idle    = 2'd0,
    s_grant_i = 2'd1,
    s_grant_d = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant_d;  // 0: I was served last, 1: D was served last
  logic [CNT_W-1:0] i_cnt_q;
  logic [CNT_W-1:0] d_cnt_q;
  logic             i_req;
  logic             d_req;

  assign i_req       = i_read;
  assign d_req       = d_read | d_write;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= s_idle;
      last_grant_d <= 1'b0;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
    end else begin
      state <= state_next;
      if (i_resp) begin
        last_grant_d <= 1'b0;
        if (i_cnt_q != {CNT_W{1'b1}}) i_cnt_q <= i_cnt_q + 1'b1;
      end
      if (d_resp) begin
        last_grant_d <= 1'b1;
        if (d_cnt_q != {CNT_W{1'b1}}) d_cnt_q <= d_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (state)
      s_idle: begin
        if (i_req && d_req) state_next = last_grant_d ? s_grant_i : s_grant_d;
        else if (i_req)     state_next = s_grant_i;
        else if (d_req)     state_next = s_grant_d;
      end
      s_grant_i: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        if (mem_resp) begin
          i_resp     = 1'b1;
          state_next = s_idle;
        end
      end
      s_grant_d: begin
        // Simultaneous read and write is a writeback; the read is dropped.
        mem_read    = d_read & ~d_write;
        mem_write   = d_write;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        if (mem_resp) begin
          d_resp     = 1'b1;
          state_next = s_idle;
        end
      end
      default: state_next = s_idle;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, single-side reads, round-robin,
// writebacks, reset during a grant and counter saturation.
module tb_cache_mem_arbiter;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [LINE_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  i_grant_cnt;
  logic [CNT_W-1:0]  d_grant_cnt;

  int tests;
  int fails;

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_beef;

  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver task: one I-side line read, waits a bounded time for the strobe
  task automatic do_i_xfer(output bit ok);
    ok = 1'b0;
    @(negedge clk);
    i_read    = 1'b1;
    i_address = 16'h0080;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (mem_read) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      mem_resp  = 1'b1;
      mem_rdata = pat_a5;
      @(negedge clk);
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
    i_read    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      fails++; $display("FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    tests++;
    if ({i_grant_cnt, d_grant_cnt} !== 32'h0) begin
      fails++; $display("FAIL reset_counters: got %h/%h expected 0/0", i_grant_cnt, d_grant_cnt);
    end
    tests++;
    if (mem_address !== 16'h0 || mem_wdata !== 128'h0) begin
      fails++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", mem_address, mem_wdata);
    end
    @(negedge clk); #1;
    tests++;
    if ({mem_read, mem_write} !== 2'b00) begin
      fails++; $display("FAIL reset_idle_hold: got %b expected 00", {mem_read, mem_write});
    end
  endtask

  task automatic test_i_read();
    @(negedge clk);
    i_read = 1'b1; i_address = 16'h0040; #1;
    tests++;
    if (mem_read !== 1'b0) begin
      fails++; $display("FAIL iread_request_cycle: mem_read got %b expected 0", mem_read);
    end
    @(negedge clk); #1;
    tests++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h0040) begin
      fails++; $display("FAIL iread_strobe: got rd=%b wr=%b addr=%h expected 1 0 0040", mem_read, mem_write, mem_address);
    end
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if (i_resp !== 1'b0 || mem_read !== 1'b1) begin
      fails++; $display("FAIL iread_wait: got resp=%b rd=%b expected 0 1", i_resp, mem_read);
    end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = pat_a5; #1;
    tests++;
    if (i_resp !== 1'b1 || i_rdata !== pat_a5 || d_resp !== 1'b0) begin
      fails++; $display("FAIL iread_resp: got i_resp=%b d_resp=%b data=%h expected 1 0 %h", i_resp, d_resp, i_rdata, pat_a5);
    end
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0; i_read = 1'b0; #1;
    tests++;
    if (i_resp !== 1'b0 || mem_read !== 1'b0 || i_grant_cnt !== 16'd1) begin
      fails++; $display("FAIL iread_done: got resp=%b rd=%b cnt=%0d expected 0 0 1", i_resp, mem_read, i_grant_cnt);
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h0200;
    @(negedge clk); #1;
    tests++;
    if (mem_read !== 1'b1 || mem_address !== 16'h0200) begin
      fails++; $display("FAIL rr_first_d: got rd=%b addr=%h expected 1 0200", mem_read, mem_address);
    end
    mem_resp = 1'b1; #1;
    tests++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      fails++; $display("FAIL rr_first_resp: got d=%b i=%b expected 1 0", d_resp, i_resp);
    end
    @(negedge clk);
    mem_resp = 1'b0; d_read = 1'b0; #1;
    tests++;
    if (mem_read !== 1'b0 || d_resp !== 1'b0) begin
      fails++; $display("FAIL rr_idle_gap: got rd=%b d_resp=%b expected 0 0", mem_read, d_resp);
    end
    @(negedge clk); #1;
    tests++;
    if (mem_read !== 1'b1 || mem_address !== 16'h0100) begin
      fails++; $display("FAIL rr_then_i: got rd=%b addr=%h expected 1 0100", mem_read, mem_address);
    end
    mem_resp = 1'b1; #1;
    tests++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
      fails++; $display("FAIL rr_i_resp: got i=%b d=%b expected 1 0", i_resp, d_resp);
    end
    @(negedge clk);
    mem_resp = 1'b0; d_read = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (mem_read !== 1'b1 || mem_address !== 16'h0200) begin
      fails++; $display("FAIL rr_third_d: got rd=%b addr=%h expected 1 0200", mem_read, mem_address);
    end
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0; #1;
    tests++;
    if (d_grant_cnt !== 16'd2 || i_grant_cnt !== 16'd1) begin
      fails++; $display("FAIL rr_counts: got i=%0d d=%0d expected 1 2", i_grant_cnt, d_grant_cnt);
    end
  endtask

  task automatic test_writeback();
    @(negedge clk);
    d_write = 1'b1; d_address = 16'h1230; d_wdata = pat_beef;
    @(negedge clk); #1;
    tests++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'h1230 || mem_wdata !== pat_beef) begin
      fails++; $display("FAIL wb_strobe: got wr=%b rd=%b addr=%h data=%h expected 1 0 1230 %h", mem_write, mem_read, mem_address, mem_wdata, pat_beef);
    end
    mem_resp = 1'b1; #1;
    tests++;
    if (d_resp !== 1'b1) begin
      fails++; $display("FAIL wb_resp: got %b expected 1", d_resp);
    end
    @(negedge clk);
    mem_resp = 1'b0; d_read = 1'b1; #1;
    tests++;
    if ({mem_read, mem_write} !== 2'b00) begin
      fails++; $display("FAIL wb_idle_gap: got %b expected 00", {mem_read, mem_write});
    end
    @(negedge clk); #1;
    tests++;
    if ({mem_read, mem_write} !== 2'b01) begin
      fails++; $display("FAIL wb_read_and_write: got rd,wr=%b expected 01", {mem_read, mem_write});
    end
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0; #1;
    tests++;
    if (d_grant_cnt !== 16'd4) begin
      fails++; $display("FAIL wb_count: got %0d expected 4", d_grant_cnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    @(negedge clk);
    d_read = 1'b1; d_address = 16'h0300;
    @(negedge clk); #1;
    tests++;
    if (mem_read !== 1'b1) begin
      fails++; $display("FAIL rstmid_granted: mem_read got %b expected 1", mem_read);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_read = 1'b0; #1;
    tests++;
    if ({mem_read, mem_write} !== 2'b00) begin
      fails++; $display("FAIL rstmid_strobes: got %b expected 00", {mem_read, mem_write});
    end
    @(negedge clk);
    mem_resp = 1'b1; #1;
    tests++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
      fails++; $display("FAIL rstmid_stale_resp: got d=%b i=%b expected 0 0", d_resp, i_resp);
    end
    @(negedge clk);
    mem_resp = 1'b0; #1;
    tests++;
    if (d_grant_cnt !== 16'd0 || i_grant_cnt !== 16'd0) begin
      fails++; $display("FAIL rstmid_counts: got i=%0d d=%0d expected 0 0", i_grant_cnt, d_grant_cnt);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    @(negedge clk);
    force dut.i_cnt_q = 16'hFFFE;
    #1;
    release dut.i_cnt_q;
    do_i_xfer(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL sat_xfer1_timeout: strobe not seen, expected within 8 cycles");
    end
    #1;
    tests++;
    if (i_grant_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL sat_reach_max: got %h expected ffff", i_grant_cnt);
    end
    for (int n = 0; n < 2; n++) begin
      do_i_xfer(ok);
      tests++;
      if (!ok) begin
        fails++; $display("FAIL sat_xfer_timeout: strobe not seen on transfer %0d", n + 2);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (i_grant_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL sat_hold: got %h expected ffff", i_grant_cnt);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    pat_a5   = {16{8'hA5}};
    pat_beef = {4{32'hDEADBEEF}};
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;

    test_reset();
    test_i_read();
    test_round_robin();
    test_writeback();
    test_reset_mid_grant();
    test_saturation();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
